gshare_pht: RTL and testbench
=============================

Name: gshare_pht

Overview:
- Pattern history table for the gshare branch predictor. Sits directly downstream of the global history register.
- Hashes the fetch PC with the GHR history bits to select a 2-bit saturating counter. Returns a taken/not-taken prediction to IF.
- Trains the selected counter when the branch resolves in EX, using the index carried down the pipeline.

Parameters:
- HISTORY_WIDTH, 8, width of the GHR history and of the PHT index; table depth = 2**HISTORY_WIDTH entries.
- PC_LSB, 2, lowest PC bit used in the hash (bits below are dropped as instruction alignment).

Ports:
- clk_i  input  1  clock, all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- pc_i  input  32  fetch-stage PC.
- ghr_i  input  HISTORY_WIDTH  global history bits from the GHR.
- predict_taken_o  output  1  prediction for pc_i: MSB of the selected counter.
- predict_idx_o  output  HISTORY_WIDTH  index used for this lookup; carried down the pipeline to EX.
- predict_cnt_o  output  2  raw selected counter value, for debug/perf.
- update_en_i  input  1  a conditional branch resolved in EX this cycle.
- update_idx_i  input  HISTORY_WIDTH  index that was returned at prediction time for the resolving branch.
- br_taken_i  input  1  actual outcome of the resolving branch.

Behaviour:
- Index: idx = pc_i[PC_LSB+HISTORY_WIDTH-1:PC_LSB] XOR ghr_i. This is a combinational lookup.
- predict_idx_o = idx.
- predict_cnt_o = pht[idx].
- predict_taken_o = pht[idx][1].
- The lookup has zero-cycle latency. The table is flop-based with asynchronous read.
- Counter encoding:
  - 00 = strong not-taken
  - 01 = weak not-taken
  - 10 = weak taken
  - 11 = strong taken
- Reset (rst_i high, asynchronous): every entry is set to 01 immediately, so all predictions are not-taken.
  - Outputs follow combinationally: predict_taken_o=0, predict_cnt_o=01, predict_idx_o = hash of the current inputs.
  - Updates are ignored while rst_i is high.
  - Reset asserted mid-training discards all learned state. There is no partial-preserve.
- Update on the rising edge when update_en_i=1:
  - br_taken_i=1: pht[update_idx_i] increments, saturating at 11.
  - br_taken_i=0: pht[update_idx_i] decrements, saturating at 00.
- Only the addressed entry changes. All other entries hold.
- update_en_i=0: the table holds. update_idx_i and br_taken_i are don't-care and may be X.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update value. The new value is visible from the next cycle. There is no write-to-read bypass.
- Simultaneous lookup and update to different indices: the two are independent.
- Back-to-back updates to the same index on consecutive cycles each apply in order. Example: 01 with taken, taken gives 10 then 11.
- No handshake and no stall input. IF holds pc_i/ghr_i stable during a stall, and the output stays stable because the lookup is combinational.
- Width rule: PC_LSB+HISTORY_WIDTH must be <= 32. This is a static check in an initial/assert block.

Test Plan (HISTORY_WIDTH=4, PC_LSB=2):
- Reset:
  - Stimulus: assert rst_i, then sweep pc_i over 0x00..0x3C with ghr_i=0.
  - Required: predict_taken_o=0 and predict_cnt_o=01 for all 16 indices.
  - Required: predict_idx_o = pc_i[5:2].
- Hash:
  - Stimulus: pc_i=0x0000_0034, ghr_i=4'b0110.
  - Required: predict_idx_o=4'b1011.
  - Stimulus: ghr_i=4'b1101.
  - Required: predict_idx_o=4'b0000.
- Saturation up then down:
  - Stimulus: update_idx_i=5 with br_taken_i=1 on 3 consecutive cycles.
  - Required: pht[5] goes 01→10→11→11, and predict_taken_o=1 when idx=5.
  - Stimulus: then 4 not-taken updates.
  - Required: 11→10→01→00→00, and predict_taken_o=0.
- Same-index collision:
  - Stimulus: idx=7 with pht[7]=01; in one cycle, lookup idx 7 and update idx 7 taken.
  - Required: predict_cnt_o=01 that cycle and 10 the next.
  - Required: pht[6] and pht[8] remain 01.
- Update disabled:
  - Stimulus: update_en_i=0 with update_idx_i=X and br_taken_i=X for 10 cycles.
  - Required: all 16 entries unchanged, and no X on any output.
- Reset mid-operation:
  - Stimulus: train pht[3]=11 and pht[9]=00, then pulse rst_i between clock edges.
  - Required: both entries read 01 before the next clock edge.
  - Stimulus: an update presented in the same cycle as rst_i.
  - Required: the update is dropped.

Source files
------------

// File: rtl/gshare_pht.sv
// Gshare pattern history table: PC XOR global history selects a 2-bit counter.
// Lookup is combinational from a flop array; training happens on the rising edge.
module gshare_pht #(
  parameter int unsigned HISTORY_WIDTH = 8,
  parameter int unsigned PC_LSB        = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              pc_i,
  input  logic [HISTORY_WIDTH-1:0] ghr_i,
  output logic                     predict_taken_o,
  output logic [HISTORY_WIDTH-1:0] predict_idx_o,
  output logic [1:0]               predict_cnt_o,
  input  logic                     update_en_i,
  input  logic [HISTORY_WIDTH-1:0] update_idx_i,
  input  logic                     br_taken_i
);

  localparam int unsigned Depth = 2 ** HISTORY_WIDTH;

  if (PC_LSB + HISTORY_WIDTH > 32) begin : gen_width_check
    $error("gshare_pht: PC_LSB + HISTORY_WIDTH must not exceed 32");
  end

  logic [1:0]               pht_q [Depth];
  logic [1:0]               pht_d [Depth];
  logic [HISTORY_WIDTH-1:0] lookup_idx;
  logic [1:0]               upd_cur;

  // Alignment bits and bits above the hash window are intentionally ignored.
  logic unused_pc;
  assign unused_pc = ^pc_i;

  assign lookup_idx      = pc_i[PC_LSB +: HISTORY_WIDTH] ^ ghr_i;
  assign predict_idx_o   = lookup_idx;
  assign predict_cnt_o   = pht_q[lookup_idx];
  assign predict_taken_o = pht_q[lookup_idx][1];

  always_comb begin
    pht_d   = pht_q;
    upd_cur = 2'b00;
    if (update_en_i) begin
      upd_cur = pht_q[update_idx_i];
      if (br_taken_i) begin
        if (upd_cur != 2'b11) pht_d[update_idx_i] = upd_cur + 2'd1;
      end else begin
        if (upd_cur != 2'b00) pht_d[update_idx_i] = upd_cur - 2'd1;
      end
    end
  end

  // Reset seeds every entry as weak not-taken; no write-to-read bypass.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) pht_q[i] <= 2'b01;
    end else begin
      pht_q <= pht_d;
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Directed self-checking bench for gshare_pht with a 16-entry table.
module tb_gshare_pht;

  localparam int unsigned HW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc;
  logic [HW-1:0] ghr;
  logic          predict_taken;
  logic [HW-1:0] predict_idx;
  logic [1:0]    predict_cnt;
  logic          update_en;
  logic [HW-1:0] update_idx;
  logic          br_taken;

  int checks = 0;
  int passes = 0;

  gshare_pht #(
    .HISTORY_WIDTH(HW),
    .PC_LSB       (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pc_i           (pc),
    .ghr_i          (ghr),
    .predict_taken_o(predict_taken),
    .predict_idx_o  (predict_idx),
    .predict_cnt_o  (predict_cnt),
    .update_en_i    (update_en),
    .update_idx_i   (update_idx),
    .br_taken_i     (br_taken)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1;
    ghr = '0;
    #3;
    for (int i = 0; i < 16; i++) begin
      pc = 32'(i) << 2;
      #1;
      checks++;
      if (predict_taken !== 1'b0) $display("FAIL reset_taken[%0d]: got %b want 0", i, predict_taken);
      else passes++;
      checks++;
      if (predict_cnt !== 2'b01) $display("FAIL reset_cnt[%0d]: got %b want 01", i, predict_cnt);
      else passes++;
      checks++;
      if (predict_idx !== 4'(i)) $display("FAIL reset_idx[%0d]: got %h want %h", i, predict_idx, i);
      else passes++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_hash;
    @(negedge clk);
    pc  = 32'h0000_0034;
    ghr = 4'b0110;
    #1;
    checks++;
    if (predict_idx !== 4'b1011) $display("FAIL hash_a: got %b want 1011", predict_idx);
    else passes++;
    ghr = 4'b1101;
    #1;
    checks++;
    if (predict_idx !== 4'b0000) $display("FAIL hash_b: got %b want 0000", predict_idx);
    else passes++;
    ghr = '0;
  endtask

  task automatic test_saturation;
    logic [1:0] exp_up [3];
    logic [1:0] exp_dn [4];
    exp_up = '{2'b10, 2'b11, 2'b11};
    exp_dn = '{2'b10, 2'b01, 2'b00, 2'b00};
    @(negedge clk);
    pc         = 32'd5 << 2;
    update_en  = 1'b1;
    update_idx = 4'd5;
    br_taken   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (predict_cnt !== exp_up[i]) $display("FAIL sat_up[%0d]: got %b want %b", i, predict_cnt, exp_up[i]);
      else passes++;
    end
    checks++;
    if (predict_taken !== 1'b1) $display("FAIL sat_up_taken: got %b want 1", predict_taken);
    else passes++;
    br_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (predict_cnt !== exp_dn[i]) $display("FAIL sat_dn[%0d]: got %b want %b", i, predict_cnt, exp_dn[i]);
      else passes++;
    end
    update_en = 1'b0;
    checks++;
    if (predict_taken !== 1'b0) $display("FAIL sat_dn_taken: got %b want 0", predict_taken);
    else passes++;
  endtask

  task automatic test_collision;
    @(negedge clk);
    pc         = 32'd7 << 2;
    update_en  = 1'b1;
    update_idx = 4'd7;
    br_taken   = 1'b1;
    #1;
    checks++;
    if (predict_cnt !== 2'b01) $display("FAIL collide_pre: got %b want 01", predict_cnt);
    else passes++;
    @(posedge clk);
    #1;
    update_en = 1'b0;
    checks++;
    if (predict_cnt !== 2'b10) $display("FAIL collide_post: got %b want 10", predict_cnt);
    else passes++;
    pc = 32'd6 << 2;
    #1;
    checks++;
    if (predict_cnt !== 2'b01) $display("FAIL collide_nb6: got %b want 01", predict_cnt);
    else passes++;
    pc = 32'd8 << 2;
    #1;
    checks++;
    if (predict_cnt !== 2'b01) $display("FAIL collide_nb8: got %b want 01", predict_cnt);
    else passes++;
  endtask

  task automatic test_update_disabled;
    logic [1:0] exp_tab [16];
    for (int i = 0; i < 16; i++) exp_tab[i] = 2'b01;
    exp_tab[5] = 2'b00;
    exp_tab[7] = 2'b10;
    @(negedge clk);
    update_en  = 1'b0;
    update_idx = 'x;
    br_taken   = 1'bx;
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      pc = 32'(i) << 2;
      #1;
      checks++;
      if (predict_cnt !== exp_tab[i]) $display("FAIL hold_cnt[%0d]: got %b want %b", i, predict_cnt, exp_tab[i]);
      else passes++;
      checks++;
      if ($isunknown({predict_taken, predict_idx}) || predict_taken !== exp_tab[i][1])
        $display("FAIL hold_out[%0d]: got taken=%b idx=%h want taken=%b idx=%h",
                 i, predict_taken, predict_idx, exp_tab[i][1], i);
      else passes++;
    end
  endtask

  task automatic test_reset_mid;
    // pht[3]: 01 -> 10 -> 11 ; pht[9]: 01 -> 00
    @(negedge clk);
    update_en  = 1'b1;
    update_idx = 4'd3;
    br_taken   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    update_idx = 4'd9;
    br_taken   = 1'b0;
    @(posedge clk);
    #1;
    update_en = 1'b0;
    pc        = 32'd9 << 2;
    #1;
    checks++;
    if (predict_cnt !== 2'b00) $display("FAIL mid_train9: got %b want 00", predict_cnt);
    else passes++;
    @(negedge clk);
    pc         = 32'd3 << 2;
    update_en  = 1'b1;
    update_idx = 4'd9;
    br_taken   = 1'b1;
    #1;
    checks++;
    if (predict_cnt !== 2'b11) $display("FAIL mid_train3: got %b want 11", predict_cnt);
    else passes++;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (predict_cnt !== 2'b01 || predict_taken !== 1'b0)
      $display("FAIL mid_rst3: got cnt=%b taken=%b want cnt=01 taken=0", predict_cnt, predict_taken);
    else passes++;
    pc = 32'd9 << 2;
    #1;
    checks++;
    if (predict_cnt !== 2'b01) $display("FAIL mid_rst9: got %b want 01", predict_cnt);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (predict_cnt !== 2'b01) $display("FAIL mid_rst_upd_in_rst: got %b want 01", predict_cnt);
    else passes++;
    @(negedge clk);
    rst       = 1'b0;
    update_en = 1'b0;
    #1;
    checks++;
    if (predict_cnt !== 2'b01) $display("FAIL mid_drop9: got %b want 01", predict_cnt);
    else passes++;
    pc = 32'd5 << 2;
    #1;
    checks++;
    if (predict_cnt !== 2'b01) $display("FAIL mid_clear5: got %b want 01", predict_cnt);
    else passes++;
  endtask

  initial begin
    rst        = 1'b1;
    pc         = '0;
    ghr        = '0;
    update_en  = 1'b0;
    update_idx = '0;
    br_taken   = 1'b0;
    test_reset();
    test_hash();
    test_saturation();
    test_collision();
    test_update_disabled();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
